// File: rtl/fft_pkg.sv
// Shared widths, complex type and fixed-point helpers
// for the radix-2 FFT butterfly datapath.
package fft_pkg;

  localparam int FFT_DATA_W    = 16;
  localparam int FFT_TWID_W    = 16;
  localparam int FFT_ADDR_SIZE = 5;

  typedef struct packed {
    logic signed [FFT_DATA_W-1:0] re;
    logic signed [FFT_DATA_W-1:0] im;
  } cplx_t;

  // Clamp v into the signed range of a w-bit value.
  function automatic logic signed [63:0] sat_w(
    input logic signed [63:0] v,
    input int                 w
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi)
      return hi;
    else if (v < lo)
      return lo;
    else
      return v;
  endfunction

  // Round half up, then arithmetic shift right by sh (sh >= 1).
  function automatic logic signed [63:0] rnd_shr(
    input logic signed [63:0] v,
    input int                 sh
  );
    return (v + (64'sd1 <<< (sh - 1))) >>> sh;
  endfunction

endpackage

// File: rtl/cplx_mult.sv
// Butterfly stage 1: registered four-product complex multiply
// of B by the twiddle, with A, addresses and valid delayed alongside.
module cplx_mult
  import fft_pkg::*;
#(
  parameter int DATA_W    = FFT_DATA_W,
  parameter int TWID_W    = FFT_TWID_W,
  parameter int ADDR_SIZE = FFT_ADDR_SIZE
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            valid,
  input  logic [ADDR_SIZE-1:0]            addr_a,
  input  logic [ADDR_SIZE-1:0]            addr_b,
  input  logic signed [DATA_W-1:0]        a_re,
  input  logic signed [DATA_W-1:0]        a_im,
  input  logic signed [DATA_W-1:0]        b_re,
  input  logic signed [DATA_W-1:0]        b_im,
  input  logic signed [TWID_W-1:0]        tw_re,
  input  logic signed [TWID_W-1:0]        tw_im,
  output logic                            valid_q,
  output logic [ADDR_SIZE-1:0]            addr_a_q,
  output logic [ADDR_SIZE-1:0]            addr_b_q,
  output logic signed [DATA_W-1:0]        a_re_q,
  output logic signed [DATA_W-1:0]        a_im_q,
  output logic signed [DATA_W+TWID_W-1:0] p_rr,
  output logic signed [DATA_W+TWID_W-1:0] p_ii,
  output logic signed [DATA_W+TWID_W-1:0] p_ri,
  output logic signed [DATA_W+TWID_W-1:0] p_ir
);

  localparam int PW = DATA_W + TWID_W;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      a_re_q   <= '0;
      a_im_q   <= '0;
      p_rr     <= '0;
      p_ii     <= '0;
      p_ri     <= '0;
      p_ir     <= '0;
    end else begin
      valid_q  <= valid;
      addr_a_q <= addr_a;
      addr_b_q <= addr_b;
      a_re_q   <= a_re;
      a_im_q   <= a_im;
      p_rr     <= PW'(b_re) * PW'(tw_re);
      p_ii     <= PW'(b_im) * PW'(tw_im);
      p_ri     <= PW'(b_re) * PW'(tw_im);
      p_ir     <= PW'(b_im) * PW'(tw_re);
    end
  end

endmodule

// File: rtl/fft_butterfly.sv
// Radix-2 DIT butterfly, 2-cycle pipeline: X = A + W*B, Y = A - W*B.
// Define FFT_BFLY_SCALE_EN to halve X and Y before saturation.
module fft_butterfly
  import fft_pkg::*;
#(
  parameter int DATA_W    = FFT_DATA_W,
  parameter int TWID_W    = FFT_TWID_W,
  parameter int ADDR_SIZE = FFT_ADDR_SIZE
) (
  input  logic                     i_CLK,
  input  logic                     i_RST_N,
  input  logic                     i_valid,
  input  logic [ADDR_SIZE-1:0]     i_addr_A,
  input  logic [ADDR_SIZE-1:0]     i_addr_B,
  input  logic signed [DATA_W-1:0] i_A_re,
  input  logic signed [DATA_W-1:0] i_A_im,
  input  logic signed [DATA_W-1:0] i_B_re,
  input  logic signed [DATA_W-1:0] i_B_im,
  input  logic signed [TWID_W-1:0] i_tw_re,
  input  logic signed [TWID_W-1:0] i_tw_im,
  input  logic                     i_clr_ovf,
  output logic                     o_valid,
  output logic [ADDR_SIZE-1:0]     o_wraddr_A,
  output logic [ADDR_SIZE-1:0]     o_wraddr_B,
  output logic signed [DATA_W-1:0] o_X_re,
  output logic signed [DATA_W-1:0] o_X_im,
  output logic signed [DATA_W-1:0] o_Y_re,
  output logic signed [DATA_W-1:0] o_Y_im,
  output logic                     o_ovf
);

  localparam int PW = DATA_W + TWID_W;

  logic                     v1;
  logic [ADDR_SIZE-1:0]     addr_a1;
  logic [ADDR_SIZE-1:0]     addr_b1;
  logic signed [DATA_W-1:0] a_re1;
  logic signed [DATA_W-1:0] a_im1;
  logic signed [PW-1:0]     p_rr;
  logic signed [PW-1:0]     p_ii;
  logic signed [PW-1:0]     p_ri;
  logic signed [PW-1:0]     p_ir;

  cplx_mult #(
    .DATA_W    (DATA_W),
    .TWID_W    (TWID_W),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_mult (
    .clk      (i_CLK),
    .rst_n    (i_RST_N),
    .valid    (i_valid),
    .addr_a   (i_addr_A),
    .addr_b   (i_addr_B),
    .a_re     (i_A_re),
    .a_im     (i_A_im),
    .b_re     (i_B_re),
    .b_im     (i_B_im),
    .tw_re    (i_tw_re),
    .tw_im    (i_tw_im),
    .valid_q  (v1),
    .addr_a_q (addr_a1),
    .addr_b_q (addr_b1),
    .a_re_q   (a_re1),
    .a_im_q   (a_im1),
    .p_rr     (p_rr),
    .p_ii     (p_ii),
    .p_ri     (p_ri),
    .p_ir     (p_ir)
  );

  logic signed [PW:0]       p_re_w;
  logic signed [PW:0]       p_im_w;
  logic signed [DATA_W:0]   p_re;
  logic signed [DATA_W:0]   p_im;
  logic signed [DATA_W+1:0] sum [4];
  logic signed [63:0]       pre [4];
  logic signed [DATA_W-1:0] res [4];
  logic [3:0]               clip;

  // Component order in sum/res: X_re, X_im, Y_re, Y_im.
  always_comb begin
    p_re_w = {p_rr[PW-1], p_rr} - {p_ii[PW-1], p_ii};
    p_im_w = {p_ri[PW-1], p_ri} + {p_ir[PW-1], p_ir};
    p_re   = (DATA_W+1)'(rnd_shr(64'(p_re_w), TWID_W - 1));
    p_im   = (DATA_W+1)'(rnd_shr(64'(p_im_w), TWID_W - 1));
    sum[0] = {a_re1[DATA_W-1], a_re1[DATA_W-1], a_re1}
           + {p_re[DATA_W], p_re};
    sum[1] = {a_im1[DATA_W-1], a_im1[DATA_W-1], a_im1}
           + {p_im[DATA_W], p_im};
    sum[2] = {a_re1[DATA_W-1], a_re1[DATA_W-1], a_re1}
           - {p_re[DATA_W], p_re};
    sum[3] = {a_im1[DATA_W-1], a_im1[DATA_W-1], a_im1}
           - {p_im[DATA_W], p_im};
    for (int k = 0; k < 4; k++) begin
`ifdef FFT_BFLY_SCALE_EN
      pre[k] = rnd_shr(64'(sum[k]), 1);
`else
      pre[k] = 64'(sum[k]);
`endif
      res[k]  = DATA_W'(sat_w(pre[k], DATA_W));
      clip[k] = (sat_w(pre[k], DATA_W) != pre[k]);
    end
  end

  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      o_valid    <= 1'b0;
      o_wraddr_A <= '0;
      o_wraddr_B <= '0;
      o_X_re     <= '0;
      o_X_im     <= '0;
      o_Y_re     <= '0;
      o_Y_im     <= '0;
      o_ovf      <= 1'b0;
    end else begin
      o_valid    <= v1;
      o_wraddr_A <= addr_a1;
      o_wraddr_B <= addr_b1;
      o_X_re     <= res[0];
      o_X_im     <= res[1];
      o_Y_re     <= res[2];
      o_Y_im     <= res[3];
      // A fresh overflow beats a simultaneous clear.
      if (v1 && |clip)
        o_ovf <= 1'b1;
      else if (i_clr_ovf)
        o_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_butterfly.sv
// Self-checking bench for fft_butterfly: directed vectors,
// corner sequences and a random stream against a real-valued model.
module tb_fft_butterfly;
  import fft_pkg::*;

  logic               clk;
  logic               rst_n;
  logic               valid;
  logic [4:0]         addr_a;
  logic [4:0]         addr_b;
  logic signed [15:0] a_re, a_im, b_re, b_im, tw_re, tw_im;
  logic               clr;
  logic               o_valid;
  logic [4:0]         wa, wb;
  logic signed [15:0] x_re, x_im, y_re, y_im;
  logic               ovf;

  int total = 0;
  int bad   = 0;

  fft_butterfly dut (
    .i_CLK      (clk),
    .i_RST_N    (rst_n),
    .i_valid    (valid),
    .i_addr_A   (addr_a),
    .i_addr_B   (addr_b),
    .i_A_re     (a_re),
    .i_A_im     (a_im),
    .i_B_re     (b_re),
    .i_B_im     (b_im),
    .i_tw_re    (tw_re),
    .i_tw_im    (tw_im),
    .i_clr_ovf  (clr),
    .o_valid    (o_valid),
    .o_wraddr_A (wa),
    .o_wraddr_B (wb),
    .o_X_re     (x_re),
    .o_X_im     (x_im),
    .o_Y_re     (y_re),
    .o_Y_im     (y_im),
    .o_ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int ar, ai, br, bi, wr, wi;
    int xr, xi, yr, yi;
    bit ov;
  } vec_t;

  typedef struct {
    bit v;
    bit clr;
    int ar, ai, br, bi, wr, wi;
    int aa, ab;
  } drv_t;

  task automatic chk(string name, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit v, int ar, int ai, int br, int bi,
                       int wr, int wi, int aa, int ab, bit c);
    valid  = v;
    a_re   = 16'(ar);
    a_im   = 16'(ai);
    b_re   = 16'(br);
    b_im   = 16'(bi);
    tw_re  = 16'(wr);
    tw_im  = 16'(wi);
    addr_a = 5'(aa);
    addr_b = 5'(ab);
    clr    = c;
  endtask

  task automatic idle(bit c);
    drive(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, c);
  endtask

  function automatic longint rnd_div(real v, real d);
    return longint'($floor(v / d + 0.5));
  endfunction

  function automatic longint clamp(longint v, inout bit c);
    if (v > 32767) begin c = 1; return 32767; end
    if (v < -32768) begin c = 1; return -32768; end
    return v;
  endfunction

  // Butterfly from its arithmetic definition in real numbers.
  task automatic model(input int ar, ai, br, bi, wr, wi,
                       output int xr, xi, yr, yi, output bit c);
    longint pr, pi, s [4];
    pr = rnd_div(real'(br) * wr - real'(bi) * wi, 32768.0);
    pi = rnd_div(real'(br) * wi + real'(bi) * wr, 32768.0);
    if (pr > 65535) pr -= 131072;
    if (pi > 65535) pi -= 131072;
    s[0] = ar + pr;
    s[1] = ai + pi;
    s[2] = ar - pr;
    s[3] = ai - pi;
    c = 0;
    for (int k = 0; k < 4; k++) begin
`ifdef FFT_BFLY_SCALE_EN
      s[k] = rnd_div(real'(s[k]), 2.0);
`endif
      s[k] = clamp(s[k], c);
    end
    xr = int'(s[0]);
    xi = int'(s[1]);
    yr = int'(s[2]);
    yi = int'(s[3]);
  endtask

  function automatic int rval();
    case ($urandom_range(0, 7))
      0: return 32767;
      1: return -32768;
      2: return 0;
      default: return int'($urandom_range(0, 65535)) - 32768;
    endcase
  endfunction

  vec_t vt [4];
  drv_t prev, cur;

  initial begin
    int mr, mi, nr, ni;
    bit mc, ovf_m;

    vt[0] = '{1000, 0, 200, 0, 32767, 0, 1200, 0, 800, 0, 0};
    vt[1] = '{50, 300, 100, 0, 0, -32767, 50, 200, 50, 400, 0};
    vt[2] = '{32000, 0, 32000, 0, 32767, 0, 32767, 0, 1, 0, 1};
    vt[3] = '{32767, 0, -32768, 0, -32768, 0, 32767, 0, -1, 0, 1};
`ifdef FFT_BFLY_SCALE_EN
    vt[0].xr = 600;  vt[0].yr = 400;
    vt[1].xr = 25;   vt[1].xi = 100;
    vt[1].yr = 25;   vt[1].yi = 200;
    vt[2].xr = 32000; vt[2].ov = 0;
    vt[3].yr = 0;
`endif

    rst_n = 1'b0;
    idle(1'b0);
    step();
    step();
    chk("rst_valid", o_valid, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_xre", x_re, 0);
    chk("rst_yim", y_im, 0);
    chk("rst_wa", wa, 0);
    rst_n = 1'b1;
    step();

    // Directed vectors: single pulse, two-edge latency.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, vt[i].ar, vt[i].ai, vt[i].br, vt[i].bi,
            vt[i].wr, vt[i].wi, i, i + 16, 1'b1);
      step();
      idle(1'b0);
      chk($sformatf("v%0d_early", i), o_valid, 0);
      step();
      chk($sformatf("v%0d_valid", i), o_valid, 1);
      chk($sformatf("v%0d_xre", i), x_re, vt[i].xr);
      chk($sformatf("v%0d_xim", i), x_im, vt[i].xi);
      chk($sformatf("v%0d_yre", i), y_re, vt[i].yr);
      chk($sformatf("v%0d_yim", i), y_im, vt[i].yi);
      chk($sformatf("v%0d_ovf", i), ovf, vt[i].ov);
      chk($sformatf("v%0d_wa", i), wa, i);
      chk($sformatf("v%0d_wb", i), wb, i + 16);
      step();
      chk($sformatf("v%0d_drop", i), o_valid, 0);
    end

    // Sticky flag holds, clears, and set beats clear.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ovf_hold", ovf, 1);
    end
    idle(1'b1);
    step();
    idle(1'b0);
    chk("ovf_clr", ovf, 0);
    drive(1'b1, 32767, 0, -32768, 0, -32768, 0, 0, 0, 1'b0);
    step();
    idle(1'b1);
    step();
    idle(1'b0);
    chk("ovf_set_wins", ovf, 1);
    idle(1'b1);
    step();
    idle(1'b0);
    chk("ovf_clr2", ovf, 0);

    // Back-to-back stream of 8 with grouped addresses.
    for (int i = 0; i < 10; i++) begin
      if (i < 8)
        drive(1'b1, 100 * i, -i, 7, 3, 16384, 0,
              (i < 4) ? i : i + 4, (i < 4) ? i + 4 : i + 8, 1'b0);
      else
        idle(1'b0);
      step();
      if (i >= 1) begin
        chk($sformatf("st%0d_valid", i), o_valid, (i - 1) < 8);
        if (i - 1 < 8) begin
          chk($sformatf("st%0d_wa", i), wa,
              (i - 1 < 4) ? i - 1 : i + 3);
          chk($sformatf("st%0d_wb", i), wb,
              (i - 1 < 4) ? i + 3 : i + 7);
        end
      end
    end
    step();

    // Random stream with random valid and clear.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    ovf_m = 0;
    prev  = '{default: 0};
    for (int i = 0; i < 400; i++) begin
      if (i < 398) begin
        cur.v   = ($urandom_range(0, 3) != 0);
        cur.clr = ($urandom_range(0, 7) == 0);
        cur.ar  = rval();
        cur.ai  = rval();
        cur.br  = rval();
        cur.bi  = rval();
        cur.wr  = rval();
        cur.wi  = rval();
        cur.aa  = int'($urandom_range(0, 31));
        cur.ab  = int'($urandom_range(0, 31));
      end else
        cur = '{default: 0};
      drive(cur.v, cur.ar, cur.ai, cur.br, cur.bi,
            cur.wr, cur.wi, cur.aa, cur.ab, cur.clr);
      step();
      if (i >= 1) begin
        model(prev.ar, prev.ai, prev.br, prev.bi, prev.wr, prev.wi,
              mr, mi, nr, ni, mc);
        if (prev.v && mc)
          ovf_m = 1;
        else if (cur.clr)
          ovf_m = 0;
        chk("rnd_valid", o_valid, prev.v);
        chk("rnd_ovf", ovf, ovf_m);
        if (prev.v) begin
          chk("rnd_xre", x_re, mr);
          chk("rnd_xim", x_im, mi);
          chk("rnd_yre", y_re, nr);
          chk("rnd_yim", y_im, ni);
          chk("rnd_wa", wa, prev.aa);
          chk("rnd_wb", wb, prev.ab);
        end
      end
      prev = cur;
    end

    // Reset mid-pipeline with the flag set and two ops in flight.
    drive(1'b1, 32767, 0, -32768, 0, -32768, 0, 3, 4, 1'b0);
    step();
    idle(1'b0);
    step();
    chk("mid_pre_ovf", ovf, 1);
    drive(1'b1, 1000, 0, 200, 0, 32767, 0, 9, 10, 1'b0);
    step();
    drive(1'b1, 32767, 0, -32768, 0, -32768, 0, 11, 12, 1'b0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    idle(1'b0);
    chk("mid_rst_valid", o_valid, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("mid%0d_valid", i), o_valid, 0);
      chk($sformatf("mid%0d_out", i),
          longint'(x_re | x_im | y_re | y_im), 0);
      chk($sformatf("mid%0d_addr", i), longint'({wa, wb}), 0);
      chk($sformatf("mid%0d_ovf", i), ovf, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
